// File: rtl/ysyx_20020207_pkg.sv
// Shared definitions for the ysyx_20020207 instruction fetch path:
// FSM state encoding, AXI read response codes and the error-instruction word.
package ysyx_20020207_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit: latches a PC pulse, fetches the word over AXI4-Lite
// (AR/R only) and hands it to decode via valid/ready, with a one-entry PC buffer.
module ysyx_20020207_ifu
  import ysyx_20020207_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_ready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fetch_err
);

  ifu_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_inst_valid;
  logic                  r_fetch_err;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic                  r_pend_valid;

  logic                  w_accept;
  logic                  w_launch;
  logic [ADDR_WIDTH-1:0] w_launch_pc;
  logic                  w_misaligned;

  // A fresh PC arriving on the accept cycle beats whatever is buffered.
  always_comb begin
    w_accept     = (r_state == ST_HOLD) && inst_ready;
    w_launch     = ((r_state == ST_IDLE) && pc_ready) ||
                   (w_accept && (pc_ready || r_pend_valid));
    w_launch_pc  = pc_ready ? pc : r_pend_pc;
    w_misaligned = (w_launch_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            r_rready     <= 1'b0;
            r_inst       <= rdata;
            r_fetch_err  <= (rresp != RESP_OKAY);
            r_inst_valid <= 1'b1;
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Launch overrides the plain state update above (later NBA wins).
      if (w_launch) begin
        if (w_misaligned) begin
          r_inst       <= DATA_WIDTH'(INST_NOP);
          r_fetch_err  <= 1'b1;
          r_inst_valid <= 1'b1;
          r_state      <= ST_HOLD;
        end else begin
          r_araddr  <= w_launch_pc;
          r_arvalid <= 1'b1;
          r_state   <= ST_AR;
        end
      end

      if (w_accept) begin
        r_pend_valid <= 1'b0;
      end else if (pc_ready && (r_state != ST_IDLE)) begin
        r_pend_pc    <= pc;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign araddr     = r_araddr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_ysyx_20020207_ifu.sv
// Bench for ysyx_20020207_ifu: directed scenarios followed by random PC traffic
// against a transaction-level model of which PC each delivered instruction belongs to.
module tb_ysyx_20020207_ifu;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_ready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          inst_ready;
  logic          fetch_err;

  int checks = 0;
  int errors = 0;

  ysyx_20020207_ifu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_ready(pc_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[5:2] == 4'hF) return 2'b10;
    if (a[5:2] == 4'hE) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 32'h0 : mem_word(a);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 1'b1 : (resp_of(a) != 2'b00);
  endfunction

  // Transaction-level model: the PC whose instruction is owed, plus a buffered PC.
  logic          m_busy;
  logic [31:0]   m_pc;
  logic          m_pend;
  logic [31:0]   m_pend_pc;
  // Slave state
  logic          s_busy;
  logic [31:0]   s_addr;
  int            s_delay;
  logic          stall_prev;
  logic [31:0]   stall_addr;

  task automatic rand_cycle(input bit allow_pc);
    logic ar_hs, r_hs, acc;
    @(negedge clk);
    check("ar_r_exclusive", arvalid & rready, 1'b0);
    if (stall_prev) begin
      check("ar_stable_valid", arvalid, 1'b1);
      check("ar_stable_addr", araddr, stall_addr);
    end
    if (inst_valid) check("valid_owed", m_busy, 1'b1);

    arready    = ($urandom_range(0, 2) != 0);
    rvalid     = s_busy && (s_delay == 0);
    rdata      = rvalid ? mem_word(s_addr) : 32'h0;
    rresp      = rvalid ? resp_of(s_addr) : 2'b00;
    inst_ready = ($urandom_range(0, 2) == 0);
    pc_ready   = allow_pc && !pc_ready && ($urandom_range(0, 5) == 0);
    pc         = 32'h3000_0000 + ($urandom_range(0, 255) << 2) +
                 (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);

    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    acc   = inst_valid && inst_ready;
    stall_prev = arvalid && !arready;
    stall_addr = araddr;

    if (s_busy && !rvalid && s_delay > 0) s_delay--;
    if (r_hs) s_busy = 1'b0;
    if (ar_hs) begin
      check("ar_addr", araddr, m_pc);
      s_busy  = 1'b1;
      s_addr  = araddr;
      s_delay = $urandom_range(0, 3);
    end

    if (acc) begin
      check("rand_inst", inst, exp_inst(m_pc));
      check("rand_err", fetch_err, exp_err(m_pc));
      $display("txn pc=%08h inst=%08h err=%0d", m_pc, inst, fetch_err);
      if (pc_ready) begin
        m_pc = pc; m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_pend_pc; m_pend = 1'b0;
      end else begin
        m_busy = 1'b0;
      end
    end else if (pc_ready) begin
      if (!m_busy) begin
        m_busy = 1'b1; m_pc = pc;
      end else begin
        m_pend = 1'b1; m_pend_pc = pc;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs;
    rst = 1'b1; pc = '0; pc_ready = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_inst", inst, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait fetch: arvalid at N+1, rready at N+2, inst_valid at N+3.
    pc = 32'h3000_0000; pc_ready = 1'b1; arready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_araddr", araddr, 32'h3000_0000);
    @(negedge clk);
    check("t1_rready", rready, 1'b1);
    check("t1_arvalid_low", arvalid, 1'b0);
    rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
    @(negedge clk);
    check("t1_inst_valid", inst_valid, 1'b1);
    check("t1_inst", inst, 32'h0000_0413);
    check("t1_fetch_err", fetch_err, 1'b0);
    rvalid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("t1_valid_drop", inst_valid, 1'b0);

    // AR stall for 4 cycles, then slave error response.
    pc = 32'h3000_0010; pc_ready = 1'b1; arready = 1'b0; hs = 0;
    @(negedge clk);
    pc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_arvalid_hold", arvalid, 1'b1);
      check("t2_araddr_hold", araddr, 32'h3000_0010);
      @(negedge clk);
    end
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (arvalid && arready) hs++;
      @(negedge clk);
    end
    check("t2_one_ar_hs", hs, 1);
    arready = 1'b0;
    check("t2_rready", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    @(negedge clk);
    rvalid = 1'b0;
    check("t3_inst", inst, 32'hDEAD_BEEF);
    check("t3_fetch_err", fetch_err, 1'b1);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;

    // Misaligned PC: no bus access, error instruction next cycle.
    pc = 32'h3000_0002; pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    check("t4_no_arvalid", arvalid, 1'b0);
    check("t4_inst_valid", inst_valid, 1'b1);
    check("t4_inst", inst, 32'h0);
    check("t4_fetch_err", fetch_err, 1'b1);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("t4_valid_drop", inst_valid, 1'b0);

    // Decode stall with a second PC buffered; its AR follows acceptance directly.
    pc = 32'h3000_0008; pc_ready = 1'b1; arready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rdata = mem_word(32'h3000_0008); rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_held_valid", inst_valid, 1'b1);
      check("t5_held_inst", inst, mem_word(32'h3000_0008));
      pc = 32'h3000_0004; pc_ready = (i == 2);
      @(negedge clk);
    end
    pc_ready = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("t5_second_arvalid", arvalid, 1'b1);
    check("t5_second_araddr", araddr, 32'h3000_0004);
    check("t5_valid_drop", inst_valid, 1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rdata = mem_word(32'h3000_0004); rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    check("t5_second_inst", inst, mem_word(32'h3000_0004));
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;

    // Reset while waiting in R with a PC buffered: everything clears at once.
    pc = 32'h3000_0020; pc_ready = 1'b1; arready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    check("t6_in_r", rready, 1'b1);
    pc = 32'h3000_0024; pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rready", rready, 1'b0);
    check("t6_rst_arvalid", arvalid, 1'b0);
    check("t6_rst_inst_valid", inst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_idle_arvalid", arvalid, 1'b0);
      check("t6_idle_inst_valid", inst_valid, 1'b0);
    end

    // Random traffic against the model, then drain.
    m_busy = 1'b0; m_pc = '0; m_pend = 1'b0; m_pend_pc = '0;
    s_busy = 1'b0; s_addr = '0; s_delay = 0;
    stall_prev = 1'b0; stall_addr = '0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 200 && m_busy; c++) rand_cycle(1'b0);
    check("drain_done", m_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_ifu.md
# ysyx_20020207_ifu

Instruction fetch unit that sits between the PC register and the instruction bus. It is the consumer of the PC's `pc`/`pc_ready` pulse interface. It latches each new PC and issues an AXI4-Lite read (AR/R channels only) for that address. It presents the returned word to the decode stage through a valid/ready handshake. A one-entry pending register absorbs a PC that arrives while a fetch is still in flight.

## Interface
- `DATA_WIDTH`, default 32: instruction and bus data width.
- `ADDR_WIDTH`, default 32: PC and bus address width.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in ADDR_WIDTH: fetch address, valid when `pc_ready`=1.
- `pc_ready` in 1: single-cycle pulse, new PC available.
- `araddr` out ADDR_WIDTH: AXI read address.
- `arvalid` out 1: AXI read address valid.
- `arready` in 1: AXI read address accepted.
- `rdata` in DATA_WIDTH: AXI read data.
- `rresp` in 2: AXI read response.
- `rvalid` in 1: AXI read data valid.
- `rready` out 1: IFU accepts read data.
- `inst` out DATA_WIDTH: fetched instruction.
- `inst_valid` out 1: `inst`/`fetch_err` valid to decode.
- `inst_ready` in 1: decode accepts `inst`.
- `fetch_err` out 1: bus error or misaligned PC for this `inst`.

## Operation
- States:
  - IDLE: waiting for a PC.
  - AR: `arvalid`=1.
  - R: `rready`=1.
  - HOLD: `inst_valid`=1.
- IDLE, `pc_ready`=1:
  - `pc[1:0]`=0: `araddr`<=`pc`, go to AR.
  - `pc[1:0]`≠0: no bus access. `inst`<=0, `fetch_err`<=1, go to HOLD.
- AR, `arvalid`&`arready`: go to R. `araddr` and `arvalid` are stable until the handshake.
- R, `rvalid`&`rready`: `inst`<=`rdata`, `fetch_err`<=(`rresp`≠2'b00), go to HOLD.
- HOLD, `inst_ready`=1:
  - Pending register full: pending PC goes through the IDLE rules, pending register cleared.
  - Otherwise: go to IDLE.
- `pc_ready` while not in IDLE: `pc` is stored in the pending register. The fetch then proceeds as above once the current instruction is accepted.
- `pc_ready` while the pending register is already full: the new PC overwrites the pending one (last writer wins).
- `pc_ready` in the same cycle as the HOLD→accept transition: the incoming PC takes priority over a stale pending entry and is fetched directly.
- At most one outstanding AXI transaction at a time. `arvalid` and `rready` are never high together.

## Timing
- Reset values:
  - state IDLE, pending register empty.
  - `arvalid`=0, `rready`=0, `inst_valid`=0, `fetch_err`=0.
  - `araddr`=0, `inst`=0.
- All outputs are registered.
- `pc_ready` at cycle N (IDLE) → `arvalid`=1 at N+1.
- AR handshake at M → `rready`=1 at M+1.
- R handshake at K → `inst_valid`=1 at K+1.
- Zero-wait-state bus: `pc_ready` to `inst_valid` is 3 cycles minimum.
- `inst_valid` stays high, with `inst` and `fetch_err` stable, until the cycle `inst_ready`=1; it deasserts the next cycle.
- With a pending PC, `arvalid` rises the cycle after acceptance (no IDLE bubble).
- Misaligned PC: `inst_valid` at N+1.
- `rst` mid-transaction: all state and outputs clear immediately. The outstanding AXI transaction is abandoned; the slave shares `rst`.

## Structure
- Shared package `ysyx_20020207_pkg` holds:
  - the state enum (IDLE/AR/R/HOLD);
  - the AXI response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11);
  - the NOP/error instruction constant (0).
- Single module, no sub-modules.
- The pending register is a PC plus a valid bit inside the same module.

## Test plan
- Reset then `pc_ready` with `pc`=32'h30000000, zero-wait slave returning 32'h00000413:
  - `araddr`=32'h30000000 at N+1;
  - `inst`=32'h00000413 with `inst_valid` at N+3;
  - `fetch_err`=0.
- Slave holds `arready`=0 for 4 cycles: `arvalid`/`araddr` are stable throughout; exactly one AR handshake.
- `rresp`=2'b10 with `rdata`=32'hDEADBEEF: `inst`=32'hDEADBEEF, `fetch_err`=1.
- `pc`=32'h30000002: no `arvalid`, `inst_valid` at N+1, `inst`=0, `fetch_err`=1.
- `inst_ready`=0 for 5 cycles while a second `pc_ready` (32'h30000004) arrives:
  - first instruction is held;
  - second AR with `araddr`=32'h30000004 issues the cycle after acceptance.
- `rst` asserted while in state R: `rready`, `inst_valid` and `arvalid` drop immediately. After release, the IFU stays idle until the next `pc_ready`.
